// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller: instruction fields,
// memory handshake and every control enable/select the controller drives.
interface multicycle_control_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retired;
  logic       err;
  logic [3:0] state;

  modport master (
    input  run, opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retired, err, state
  );

  modport slave (
    output run, opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retired, err, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath (lw, sw, R-type, beq, jr)
// with memory wait states and a sticky illegal-instruction trap.
module multicycle_control (
  input logic               clk,
  input logic               rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMPR  = 4'd9,
    ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_JR    = 6'h2D;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retired;
    logic       err;
  } ctl_t;

  state_t cur;
  ctl_t   ctl;
  ctl_t   gated;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= FETCH;
    end else begin
      case (cur)
        FETCH: begin
          if (bus.run && bus.mem_ready) cur <= DECODE;
        end
        DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: cur <= MEMADR;
            OP_BEQ:       cur <= BRANCH;
            OP_RTYPE:     cur <= (bus.funct == FN_JR) ? JUMPR : EXEC;
            default:      cur <= ERROR;
          endcase
        end
        MEMADR: begin
          if (bus.opcode == OP_LW)      cur <= MEMRD;
          else if (bus.opcode == OP_SW) cur <= MEMWR;
          else                          cur <= ERROR;
        end
        MEMRD: begin
          if (bus.mem_ready) cur <= MEMWB;
        end
        MEMWB:  cur <= FETCH;
        MEMWR: begin
          if (bus.mem_ready) cur <= FETCH;
        end
        EXEC:   cur <= RWB;
        RWB:    cur <= FETCH;
        BRANCH: cur <= FETCH;
        JUMPR:  cur <= FETCH;
        ERROR:  cur <= ERROR;
        default: cur <= ERROR;
      endcase
    end
  end

  // Outputs depend on state only, except for run/mem_ready qualifying FETCH and MEMWR.
  always_comb begin
    ctl = '0;
    case (cur)
      FETCH: begin
        if (bus.run) begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = 2'b01;
          ctl.ir_write  = bus.mem_ready;
          ctl.pc_write  = bus.mem_ready;
        end
      end
      DECODE: begin
        ctl.alu_src_b = 2'b11;
      end
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.retired    = 1'b1;
      end
      MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        ctl.retired   = bus.mem_ready;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        ctl.retired   = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.retired       = 1'b1;
      end
      JUMPR: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = 2'b11;
        ctl.retired   = 1'b1;
      end
      ERROR: begin
        ctl.err = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  // Holding reset must silence every enable, even if run and mem_ready are high.
  assign gated = rst_n ? ctl : '0;

  assign bus.pc_write      = gated.pc_write;
  assign bus.pc_write_cond = gated.pc_write_cond;
  assign bus.iord          = gated.iord;
  assign bus.mem_read      = gated.mem_read;
  assign bus.mem_write     = gated.mem_write;
  assign bus.ir_write      = gated.ir_write;
  assign bus.mem_to_reg    = gated.mem_to_reg;
  assign bus.reg_dst       = gated.reg_dst;
  assign bus.reg_write     = gated.reg_write;
  assign bus.alu_src_a     = gated.alu_src_a;
  assign bus.alu_src_b     = gated.alu_src_b;
  assign bus.alu_op        = gated.alu_op;
  assign bus.pc_source     = gated.pc_source;
  assign bus.retired       = gated.retired;
  assign bus.err           = gated.err;
  assign bus.state         = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: walks each instruction
// class through its state sequence and checks the full control word per cycle.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: pcw pcwc iord mrd mwr irw m2r rdst rw asa | asb | aop | psrc | ret | err
  logic [17:0] ctl;
  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.retired, bus.err};

  localparam logic [17:0] C_IDLE    = 18'b0000000000_00_00_00_0_0;
  localparam logic [17:0] C_FET_RDY = 18'b1001010000_01_00_00_0_0;
  localparam logic [17:0] C_FET_WT  = 18'b0001000000_01_00_00_0_0;
  localparam logic [17:0] C_DECODE  = 18'b0000000000_11_00_00_0_0;
  localparam logic [17:0] C_MEMADR  = 18'b0000000001_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD   = 18'b0011000000_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB   = 18'b0000001010_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR   = 18'b0010100000_00_00_00_0_0;
  localparam logic [17:0] C_MEMWR_D = 18'b0010100000_00_00_00_1_0;
  localparam logic [17:0] C_EXEC    = 18'b0000000001_00_10_00_0_0;
  localparam logic [17:0] C_RWB     = 18'b0000000110_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH  = 18'b0100000001_00_01_01_1_0;
  localparam logic [17:0] C_JUMPR   = 18'b1000000000_00_00_11_1_0;
  localparam logic [17:0] C_ERROR   = 18'b0000000000_00_00_00_0_1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.run = 1'b1; bus.mem_ready = 1'b1; #1;
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL reset_hold state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
    bus.run = 1'b0; bus.mem_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL reset_release state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  task automatic test_run_low();
    bus.run = 1'b0; bus.mem_ready = 1'b1;
    step();
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL run_low state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  task automatic test_lw();
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.run = 1'b1; bus.mem_ready = 1'b1; #1;
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_FET_RDY) begin
      failed++; $display("[TB] FAIL lw_fetch state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_FET_RDY);
    end
    step(); bus.run = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd1 || ctl !== C_DECODE) begin
      failed++; $display("[TB] FAIL lw_decode state=%0d ctl=%b exp state=1 ctl=%b", bus.state, ctl, C_DECODE);
    end
    step();
    tests++;
    if (bus.state !== 4'd2 || ctl !== C_MEMADR) begin
      failed++; $display("[TB] FAIL lw_memadr state=%0d ctl=%b exp state=2 ctl=%b", bus.state, ctl, C_MEMADR);
    end
    step();
    tests++;
    if (bus.state !== 4'd3 || ctl !== C_MEMRD) begin
      failed++; $display("[TB] FAIL lw_memrd state=%0d ctl=%b exp state=3 ctl=%b", bus.state, ctl, C_MEMRD);
    end
    step();
    tests++;
    if (bus.state !== 4'd4 || ctl !== C_MEMWB) begin
      failed++; $display("[TB] FAIL lw_memwb state=%0d ctl=%b exp state=4 ctl=%b", bus.state, ctl, C_MEMWB);
    end
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL lw_done state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  task automatic test_sw_wait();
    bus.opcode = 6'h2B; bus.funct = 6'h00; bus.run = 1'b1; bus.mem_ready = 1'b1;
    step(); bus.run = 1'b0; bus.mem_ready = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd1 || ctl !== C_DECODE) begin
      failed++; $display("[TB] FAIL sw_decode state=%0d ctl=%b exp state=1 ctl=%b", bus.state, ctl, C_DECODE);
    end
    step();
    tests++;
    if (bus.state !== 4'd2 || ctl !== C_MEMADR) begin
      failed++; $display("[TB] FAIL sw_memadr state=%0d ctl=%b exp state=2 ctl=%b", bus.state, ctl, C_MEMADR);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.state !== 4'd5 || ctl !== C_MEMWR) begin
        failed++; $display("[TB] FAIL sw_wait%0d state=%0d ctl=%b exp state=5 ctl=%b", i, bus.state, ctl, C_MEMWR);
      end
    end
    step(); bus.mem_ready = 1'b1; #1;
    tests++;
    if (bus.state !== 4'd5 || ctl !== C_MEMWR_D) begin
      failed++; $display("[TB] FAIL sw_complete state=%0d ctl=%b exp state=5 ctl=%b", bus.state, ctl, C_MEMWR_D);
    end
    step(); bus.mem_ready = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL sw_done state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  task automatic test_rtype();
    bus.opcode = 6'h00; bus.funct = 6'h16; bus.run = 1'b1; bus.mem_ready = 1'b1;
    step(); bus.run = 1'b0; bus.mem_ready = 1'b0;
    step();
    tests++;
    if (bus.state !== 4'd6 || ctl !== C_EXEC) begin
      failed++; $display("[TB] FAIL rtype_exec state=%0d ctl=%b exp state=6 ctl=%b", bus.state, ctl, C_EXEC);
    end
    step();
    tests++;
    if (bus.state !== 4'd7 || ctl !== C_RWB) begin
      failed++; $display("[TB] FAIL rtype_rwb state=%0d ctl=%b exp state=7 ctl=%b", bus.state, ctl, C_RWB);
    end
    step();
    tests++;
    if (bus.state !== 4'd0) begin
      failed++; $display("[TB] FAIL rtype_done state=%0d exp 0", bus.state);
    end
  endtask

  task automatic test_jr();
    bus.opcode = 6'h00; bus.funct = 6'h2D; bus.run = 1'b1; bus.mem_ready = 1'b1;
    step(); bus.run = 1'b0;
    step();
    tests++;
    if (bus.state !== 4'd9 || ctl !== C_JUMPR) begin
      failed++; $display("[TB] FAIL jr_jumpr state=%0d ctl=%b exp state=9 ctl=%b", bus.state, ctl, C_JUMPR);
    end
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL jr_done state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  task automatic test_beq_fetch_wait();
    bus.opcode = 6'h04; bus.funct = 6'h00; bus.zero = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_FET_WT) begin
      failed++; $display("[TB] FAIL beq_fetch_wait state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_FET_WT);
    end
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_FET_WT) begin
      failed++; $display("[TB] FAIL beq_fetch_hold state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_FET_WT);
    end
    bus.mem_ready = 1'b1;
    step(); bus.run = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd1) begin
      failed++; $display("[TB] FAIL beq_decode state=%0d exp 1", bus.state);
    end
    step();
    tests++;
    if (bus.state !== 4'd8 || ctl !== C_BRANCH) begin
      failed++; $display("[TB] FAIL beq_branch state=%0d ctl=%b exp state=8 ctl=%b", bus.state, ctl, C_BRANCH);
    end
    step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL beq_done state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_error();
    bus.opcode = 6'h3F; bus.funct = 6'h00; bus.run = 1'b1; bus.mem_ready = 1'b1;
    step();
    step();
    tests++;
    if (bus.state !== 4'd15 || ctl !== C_ERROR) begin
      failed++; $display("[TB] FAIL err_enter state=%0d ctl=%b exp state=15 ctl=%b", bus.state, ctl, C_ERROR);
    end
    step(); step(); step();
    tests++;
    if (bus.state !== 4'd15 || ctl !== C_ERROR) begin
      failed++; $display("[TB] FAIL err_sticky state=%0d ctl=%b exp state=15 ctl=%b", bus.state, ctl, C_ERROR);
    end
    #2 rst_n = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd0 || bus.err !== 1'b0) begin
      failed++; $display("[TB] FAIL err_reset state=%0d err=%b exp state=0 err=0", bus.state, bus.err);
    end
    bus.run = 1'b0; bus.mem_ready = 1'b0;
    step(); rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset_memrd();
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.run = 1'b1; bus.mem_ready = 1'b1;
    step(); bus.mem_ready = 1'b0;
    step();
    step();
    step();
    tests++;
    if (bus.state !== 4'd3 || ctl !== C_MEMRD) begin
      failed++; $display("[TB] FAIL areset_memrd_wait state=%0d ctl=%b exp state=3 ctl=%b", bus.state, ctl, C_MEMRD);
    end
    bus.run = 1'b1; bus.mem_ready = 1'b1;
    #2 rst_n = 1'b0; #1;
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL areset_abort state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
    bus.run = 1'b0;
    step(); rst_n = 1'b1;
    step(); step();
    tests++;
    if (bus.state !== 4'd0 || ctl !== C_IDLE) begin
      failed++; $display("[TB] FAIL areset_run_low state=%0d ctl=%b exp state=0 ctl=%b", bus.state, ctl, C_IDLE);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    test_reset();
    test_run_low();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_jr();
    test_beq_fetch_wait();
    test_error();
    test_async_reset_memrd();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 run  input  1  enables fetch of the next instruction; sampled only in FETCH.
REQ-004 opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 funct  input  6  IR[5:0], valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  input  1  memory completion; an access completes in the cycle mem_ready=1 while mem_read or mem_write is asserted.
REQ-008 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  standard multicycle datapath enables and selects.
REQ-009 alu_src_b  output  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
REQ-010 alu_op  output  2  00=add, 01=sub, 10=use funct.
REQ-011 pc_source  output  2  00=ALU result, 01=ALUOut, 11=register A (jr); 10 is reserved and never driven.
REQ-012 retired  output  1  one-cycle pulse when an instruction completes.
REQ-013 err  output  1  sticky illegal-instruction flag.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 Outputs SHALL be Moore: combinational functions of state only, plus run in FETCH; any signal not listed for a state is 0.
REQ-016 Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMPR=9, ERROR=15. Codes 10-14 SHALL transition to ERROR.
REQ-017 FETCH with run=1: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-018 FETCH with run=1: ir_write and pc_write SHALL equal mem_ready. The FSM advances to DECODE only when run & mem_ready; otherwise it holds.
REQ-019 FETCH with run=0: all outputs are 0 and the FSM holds.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-021 DECODE next state by opcode: 0x23 or 0x2B -> MEMADR; 0x04 -> BRANCH; 0x00 with funct 0x2D -> JUMPR; 0x00 with any other funct (including regtoreg 0x16) -> EXEC; any other opcode -> ERROR.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for 0x23 and MEMWR for 0x2B.
REQ-023 MEMRD: mem_read=1, iord=1. The FSM holds until mem_ready, then goes to MEMWB.
REQ-024 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, retired=1; next state FETCH.
REQ-025 MEMWR: mem_write=1, iord=1. The FSM holds until mem_ready.
REQ-026 MEMWR completion: in the mem_ready cycle retired=1 and the next state is FETCH.
REQ-027 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state RWB.
REQ-028 RWB: reg_write=1, reg_dst=1, mem_to_reg=0, retired=1; next state FETCH.
REQ-029 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, retired=1; next state FETCH. PC update uses zero externally.
REQ-030 JUMPR: pc_write=1, pc_source=11, retired=1; next state FETCH.
REQ-031 ERROR: err=1 and all other outputs 0. The FSM stays in ERROR until rst_n is asserted; run has no effect there.
REQ-032 A completing memory access SHALL never coincide with a state change other than the one specified; mem_ready outside an access state SHALL be ignored.
REQ-033 Instruction latencies from FETCH completion: R-type 4 cycles, beq 3, jr 3, sw 4, lw 5, each assuming single-cycle memory; every mem_ready wait cycle adds 1.

Reset
REQ-034 While rst_n=0, state SHALL be FETCH immediately (asynchronously), and err is cleared.
REQ-035 Reset mid-access (MEMRD, MEMWR, FETCH) SHALL abort the access, and no write enable SHALL be asserted during or after reset.
REQ-036 After rst_n deasserts, the first possible fetch is on the first rising edge with run=1 & mem_ready=1.

Verification
REQ-037 lw (opcode 0x23), mem_ready always 1 -> states 0,1,2,3,4,0; retired pulses once in state 4; reg_write=1 only in state 4.
REQ-038 sw (0x2B), mem_ready low for 3 cycles in MEMWR -> mem_write held for 4 cycles, then retired=1 and state returns to 0.
REQ-039 R-type (opcode 0, funct 0x16) -> states 0,1,6,7,0; reg_dst=1 in RWB. Same stimulus with funct 0x2D -> states 0,1,9,0 with pc_source=11.
REQ-040 Opcode 0x3F -> ERROR (15), err=1 persists with run=1; pulsing rst_n low -> state 0, err=0.
REQ-041 rst_n driven low asynchronously mid-MEMRD -> state reads 0 before the next clock edge with mem_read=0; run=0 after reset -> FSM holds in FETCH with all outputs 0.
